// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between the issue-side requesters
// (master) and the alu arbiter (slave). Two ports share every field; port i
// occupies slice i of each packed vector.
interface alu_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int OP_W  = 6,
    parameter int EXC_W = 8
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*OP_W-1:0]   req_op;
    logic [1:0]          req_check_ovf;
    logic [2*XLEN-1:0]   req_next_pc;
    logic [2*XLEN-1:0]   req_rs_val;
    logic [2*XLEN-1:0]   req_rt_val;
    logic [2*XLEN-1:0]   req_const_val;
    logic [1:0]          resp_valid;
    logic [1:0]          resp_ready;
    logic [XLEN-1:0]     resp_out_val;
    logic [XLEN-1:0]     resp_br_target;
    logic                resp_br_enable;
    logic [EXC_W-1:0]    resp_exception;

    modport master (
        output req_valid, req_op, req_check_ovf, req_next_pc,
               req_rs_val, req_rt_val, req_const_val, resp_ready,
        input  req_ready, resp_valid, resp_out_val, resp_br_target,
               resp_br_enable, resp_exception
    );

    modport slave (
        input  req_valid, req_op, req_check_ovf, req_next_pc,
               req_rs_val, req_rt_val, req_const_val, resp_ready,
        output req_ready, resp_valid, resp_out_val, resp_br_target,
               resp_br_enable, resp_exception
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between the execute stage (port 0)
// and memory address generation (port 1). A request is accepted in IDLE or in
// the RESP cycle whose response handshakes, its operands are registered onto
// the alu inputs, the alu result is captured one cycle later and presented on
// the shared response bus tagged one-hot with the granted port.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration on
// contention; without it port 0 always wins contention.
module alu_arbiter #(
    parameter int XLEN  = 32,
    parameter int OP_W  = 6,
    parameter int EXC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     bus,
    output logic             busy,
    output logic [OP_W-1:0]  alu_op,
    output logic             alu_check_overflow,
    output logic [XLEN-1:0]  alu_next_pc,
    output logic [XLEN-1:0]  alu_rs_val,
    output logic [XLEN-1:0]  alu_rt_val,
    output logic [XLEN-1:0]  alu_const_val,
    input  logic [XLEN-1:0]  alu_out_val,
    input  logic [XLEN-1:0]  alu_br_target,
    input  logic             alu_br_enable,
    input  logic [EXC_W-1:0] alu_exception
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic              grant_r;
    logic              last_grant_r;
    logic [1:0]        resp_valid_r;
    logic [XLEN-1:0]   resp_out_val_r;
    logic [XLEN-1:0]   resp_br_target_r;
    logic              resp_br_enable_r;
    logic [EXC_W-1:0]  resp_exception_r;

    logic              handshake_s;
    logic              window_s;
    logic              accept_s;
    logic              sel_s;
    logic [1:0]        req_ready_s;
    logic [OP_W-1:0]   op_sel_s;
    logic              ovf_sel_s;
    logic [XLEN-1:0]   npc_sel_s;
    logic [XLEN-1:0]   rs_sel_s;
    logic [XLEN-1:0]   rt_sel_s;
    logic [XLEN-1:0]   const_sel_s;

    // resp_valid_r is one-hot on the grant, so masking with it ignores the
    // non-granted resp_ready bit.
    assign handshake_s = (state_r == RESP) && ((resp_valid_r & bus.resp_ready) != 2'b00);
    assign window_s    = (state_r == IDLE) || handshake_s;
    assign accept_s    = window_s && (bus.req_valid != 2'b00);

    // Pick the winning requester and raise its ready strobe inside the accept window
    always_comb begin
        sel_s       = 1'b0;
        req_ready_s = 2'b00;
`ifdef ALU_ARB_RR_EN
        if (bus.req_valid == 2'b11) begin
            sel_s = ~last_grant_r;
        end else begin
            sel_s = bus.req_valid[1];
        end
`else
        if (bus.req_valid[0]) begin
            sel_s = 1'b0;
        end else begin
            sel_s = bus.req_valid[1];
        end
`endif
        if (accept_s) begin
            req_ready_s = sel_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    assign op_sel_s    = sel_s ? bus.req_op[2*OP_W-1:OP_W]        : bus.req_op[OP_W-1:0];
    assign ovf_sel_s   = sel_s ? bus.req_check_ovf[1]             : bus.req_check_ovf[0];
    assign npc_sel_s   = sel_s ? bus.req_next_pc[2*XLEN-1:XLEN]   : bus.req_next_pc[XLEN-1:0];
    assign rs_sel_s    = sel_s ? bus.req_rs_val[2*XLEN-1:XLEN]    : bus.req_rs_val[XLEN-1:0];
    assign rt_sel_s    = sel_s ? bus.req_rt_val[2*XLEN-1:XLEN]    : bus.req_rt_val[XLEN-1:0];
    assign const_sel_s = sel_s ? bus.req_const_val[2*XLEN-1:XLEN] : bus.req_const_val[XLEN-1:0];

    // Arbiter FSM: latch the accepted request, capture the alu result, hold the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= IDLE;
            grant_r            <= 1'b0;
            last_grant_r       <= 1'b1;
            resp_valid_r       <= 2'b00;
            resp_out_val_r     <= {XLEN{1'b0}};
            resp_br_target_r   <= {XLEN{1'b0}};
            resp_br_enable_r   <= 1'b0;
            resp_exception_r   <= {EXC_W{1'b0}};
            alu_op             <= {OP_W{1'b0}};
            alu_check_overflow <= 1'b0;
            alu_next_pc        <= {XLEN{1'b0}};
            alu_rs_val         <= {XLEN{1'b0}};
            alu_rt_val         <= {XLEN{1'b0}};
            alu_const_val      <= {XLEN{1'b0}};
        end else begin
            if (accept_s) begin
                grant_r            <= sel_s;
                alu_op             <= op_sel_s;
                alu_check_overflow <= ovf_sel_s;
                alu_next_pc        <= npc_sel_s;
                alu_rs_val         <= rs_sel_s;
                alu_rt_val         <= rt_sel_s;
                alu_const_val      <= const_sel_s;
            end else begin
                grant_r <= grant_r;
            end
            // last_grant only moves on an accept
            last_grant_r <= accept_s ? sel_s : last_grant_r;

            case (state_r)
                IDLE: begin
                    resp_valid_r <= 2'b00;
                    state_r      <= accept_s ? EXEC : IDLE;
                end
                EXEC: begin
                    resp_out_val_r   <= alu_out_val;
                    resp_br_target_r <= alu_br_target;
                    resp_br_enable_r <= alu_br_enable;
                    resp_exception_r <= alu_exception;
                    resp_valid_r     <= grant_r ? 2'b10 : 2'b01;
                    state_r          <= RESP;
                end
                RESP: begin
                    if (handshake_s) begin
                        resp_valid_r <= 2'b00;
                        state_r      <= accept_s ? EXEC : IDLE;
                    end else begin
                        resp_valid_r <= resp_valid_r;
                        state_r      <= RESP;
                    end
                end
                default: begin
                    resp_valid_r <= 2'b00;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign busy               = (state_r != IDLE);
    assign bus.req_ready      = req_ready_s;
    assign bus.resp_valid     = resp_valid_r;
    assign bus.resp_out_val   = resp_out_val_r;
    assign bus.resp_br_target = resp_br_target_r;
    assign bus.resp_br_enable = resp_br_enable_r;
    assign bus.resp_exception = resp_exception_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives the arbiter with directed and random requests. The
// bench plays the role of the alu (computed from the registered alu inputs)
// and predicts every response directly from the request fields.
module tb_alu_arbiter;

    localparam logic [5:0] ALU_ADD = 6'h20;
    localparam logic [5:0] ALU_SUB = 6'h22;
    localparam logic [5:0] ALU_AND = 6'h24;
    localparam logic [5:0] ALU_OR  = 6'h25;
    localparam logic [5:0] ALU_XOR = 6'h26;
    localparam logic [5:0] ALU_BEQ = 6'h04;
    localparam logic [5:0] ALU_BNE = 6'h05;
    localparam logic [7:0] TRAP_OVERFLOW = 8'h0C;
    localparam logic [7:0] TRAP_STALL    = 8'h01;

    typedef struct packed {
        logic [31:0] out;
        logic [31:0] tgt;
        logic        en;
        logic [7:0]  exc;
    } alu_res_t;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.XLEN(32), .OP_W(6), .EXC_W(8)) bus();

    logic        busy;
    logic [5:0]  alu_op;
    logic        alu_check_overflow;
    logic [31:0] alu_next_pc, alu_rs_val, alu_rt_val, alu_const_val;
    logic [31:0] alu_out_val, alu_br_target;
    logic        alu_br_enable;
    logic [7:0]  alu_exception;
    alu_res_t    stub_s;

    function automatic alu_res_t alu_model(input logic [5:0] op, input logic ovf,
                                           input logic [31:0] npc, input logic [31:0] rs,
                                           input logic [31:0] rt, input logic [31:0] cst);
        alu_res_t r;
        r = '0;
        r.tgt = npc - 32'd4 + (cst << 2);
        case (op)
            ALU_ADD: begin
                r.out = rs + rt;
                if (ovf && (rs[31] == rt[31]) && (r.out[31] != rs[31])) r.exc = TRAP_OVERFLOW;
            end
            ALU_SUB: begin
                r.out = rs - rt;
                if (ovf && (rs[31] != rt[31]) && (r.out[31] != rs[31])) r.exc = TRAP_OVERFLOW;
            end
            ALU_AND: r.out = rs & rt;
            ALU_OR:  r.out = rs | rt;
            ALU_XOR: r.out = rs ^ rt;
            ALU_BEQ: r.en  = (rs == rt);
            ALU_BNE: r.en  = (rs != rt);
            default: r.exc = TRAP_STALL;
        endcase
        return r;
    endfunction

    // external alu stand-in fed by the arbiter's registered alu inputs
    always_comb begin
        stub_s        = alu_model(alu_op, alu_check_overflow, alu_next_pc,
                                  alu_rs_val, alu_rt_val, alu_const_val);
        alu_out_val   = stub_s.out;
        alu_br_target = stub_s.tgt;
        alu_br_enable = stub_s.en;
        alu_exception = stub_s.exc;
    end

    alu_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .busy               (busy),
        .alu_op             (alu_op),
        .alu_check_overflow (alu_check_overflow),
        .alu_next_pc        (alu_next_pc),
        .alu_rs_val         (alu_rs_val),
        .alu_rt_val         (alu_rt_val),
        .alu_const_val      (alu_const_val),
        .alu_out_val        (alu_out_val),
        .alu_br_target      (alu_br_target),
        .alu_br_enable      (alu_br_enable),
        .alu_exception      (alu_exception)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.req_valid     = 2'b00;
        bus.req_op        = 12'h000;
        bus.req_check_ovf = 2'b00;
        bus.req_next_pc   = 64'h0;
        bus.req_rs_val    = 64'h0;
        bus.req_rt_val    = 64'h0;
        bus.req_const_val = 64'h0;
        bus.resp_ready    = 2'b00;
    endtask

    task automatic set_req(input int port, input logic [5:0] op, input logic ovf,
                           input logic [31:0] npc, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] cst);
        bus.req_op[port*6 +: 6]         = op;
        bus.req_check_ovf[port]         = ovf;
        bus.req_next_pc[port*32 +: 32]  = npc;
        bus.req_rs_val[port*32 +: 32]   = rs;
        bus.req_rt_val[port*32 +: 32]   = rt;
        bus.req_const_val[port*32 +: 32] = cst;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // one complete request/response transaction on a single port
    task automatic run_single(input string name, input int port, input logic [5:0] op,
                              input logic ovf, input logic [31:0] npc, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [31:0] cst);
        alu_res_t   exp;
        logic [1:0] oh;
        oh  = (port == 1) ? 2'b10 : 2'b01;
        exp = alu_model(op, ovf, npc, rs, rt, cst);
        set_req(port, op, ovf, npc, rs, rt, cst);
        bus.req_valid = oh;
        #1;
        total++;
        if (bus.req_ready !== oh) begin
            bad++; $display("FAIL %s req_ready: got %b expected %b", name, bus.req_ready, oh);
        end
        tick();
        bus.req_valid = 2'b00;
        #1;
        total++;
        if ({busy, bus.req_ready, bus.resp_valid} !== {1'b1, 2'b00, 2'b00}) begin
            bad++; $display("FAIL %s exec_state: got busy=%b rdy=%b rv=%b expected 1/00/00",
                            name, busy, bus.req_ready, bus.resp_valid);
        end
        total++;
        if ({alu_op, alu_check_overflow, alu_next_pc, alu_rs_val, alu_rt_val, alu_const_val}
            !== {op, ovf, npc, rs, rt, cst}) begin
            bad++; $display("FAIL %s alu_inputs: got %h/%b/%h/%h/%h/%h expected %h/%b/%h/%h/%h/%h",
                            name, alu_op, alu_check_overflow, alu_next_pc, alu_rs_val,
                            alu_rt_val, alu_const_val, op, ovf, npc, rs, rt, cst);
        end
        tick();
        total++;
        if (bus.resp_valid !== oh) begin
            bad++; $display("FAIL %s resp_valid: got %b expected %b", name, bus.resp_valid, oh);
        end
        total++;
        if ({bus.resp_out_val, bus.resp_br_target, bus.resp_br_enable, bus.resp_exception}
            !== {exp.out, exp.tgt, exp.en, exp.exc}) begin
            bad++; $display("FAIL %s resp_data: got %h/%h/%b/%h expected %h/%h/%b/%h", name,
                            bus.resp_out_val, bus.resp_br_target, bus.resp_br_enable,
                            bus.resp_exception, exp.out, exp.tgt, exp.en, exp.exc);
        end
        bus.resp_ready = oh;
        tick();
        bus.resp_ready = 2'b00;
        total++;
        if ({busy, bus.resp_valid} !== {1'b0, 2'b00}) begin
            bad++; $display("FAIL %s back_to_idle: got busy=%b rv=%b expected 0/00",
                            name, busy, bus.resp_valid);
        end
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        total++;
        if ({busy, bus.resp_valid, bus.req_ready} !== {1'b0, 2'b00, 2'b00}) begin
            bad++; $display("FAIL reset_ctrl: got busy=%b rv=%b rdy=%b expected 0/00/00",
                            busy, bus.resp_valid, bus.req_ready);
        end
        total++;
        if ({alu_op, alu_check_overflow, alu_next_pc, alu_rs_val, alu_rt_val, alu_const_val} !== 135'h0) begin
            bad++; $display("FAIL reset_alu_inputs: got op=%h rs=%h rt=%h expected 0",
                            alu_op, alu_rs_val, alu_rt_val);
        end
        total++;
        if ({bus.resp_out_val, bus.resp_br_target, bus.resp_br_enable, bus.resp_exception} !== 73'h0) begin
            bad++; $display("FAIL reset_resp: got %h/%h/%b/%h expected 0", bus.resp_out_val,
                            bus.resp_br_target, bus.resp_br_enable, bus.resp_exception);
        end
    endtask

    task automatic test_add;
        run_single("add_p0", 0, ALU_ADD, 1'b0, 32'h100, 32'd5, 32'd7, 32'd0);
        total++;
        if (bus.resp_out_val !== 32'd12) begin
            bad++; $display("FAIL add_value: got %0d expected 12", bus.resp_out_val);
        end
    endtask

    task automatic test_overflow;
        run_single("ovf_p1", 1, ALU_ADD, 1'b1, 32'h200, 32'h7FFF_FFFF, 32'd1, 32'd0);
        total++;
        if (bus.resp_exception !== TRAP_OVERFLOW) begin
            bad++; $display("FAIL ovf_exc: got %h expected %h", bus.resp_exception, TRAP_OVERFLOW);
        end
    endtask

    task automatic test_unknown_op;
        run_single("unknown_op", 0, 6'h3F, 1'b0, 32'h300, 32'd9, 32'd9, 32'd1);
        total++;
        if (bus.resp_exception !== TRAP_STALL) begin
            bad++; $display("FAIL stall_exc: got %h expected %h", bus.resp_exception, TRAP_STALL);
        end
    endtask

    task automatic test_random;
        logic [5:0] ops [8];
        logic [31:0] rs, rt;
        ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_BEQ, ALU_BNE, 6'h3F};
        for (int i = 0; i < 24; i++) begin
            rs = $urandom;
            rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            run_single("random", int'($urandom_range(0, 1)), ops[$urandom_range(0, 7)],
                       1'($urandom_range(0, 1)), $urandom, rs, rt, $urandom);
        end
    endtask

    task automatic test_back_to_back;
        int gport [4];
        int gcyc  [4];
        int n;
        int exp_port;
        do_reset();
        set_req(0, ALU_ADD, 1'b0, 32'h0, 32'd1, 32'd1, 32'd0);
        set_req(1, ALU_ADD, 1'b0, 32'h0, 32'd10, 32'd20, 32'd0);
        bus.req_valid  = 2'b11;
        bus.resp_ready = 2'b11;
        #1;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            if (bus.resp_valid != 2'b00) begin
                total++;
                if (bus.resp_out_val !== (bus.resp_valid[1] ? 32'd30 : 32'd2)) begin
                    bad++; $display("FAIL b2b_data: got %0d for rv=%b", bus.resp_out_val, bus.resp_valid);
                end
            end
            if (bus.req_ready != 2'b00) begin
                gport[n] = bus.req_ready[1] ? 1 : 0;
                gcyc[n]  = cyc;
                n++;
            end
            tick();
        end
        total++;
        if (n != 4) begin
            bad++; $display("FAIL b2b_timeout: got %0d grants expected 4", n);
        end
        for (int i = 0; i < n; i++) begin
`ifdef ALU_ARB_RR_EN
            exp_port = i % 2;
`else
            exp_port = 0;
`endif
            total++;
            if (gport[i] !== exp_port) begin
                bad++; $display("FAIL b2b_grant%0d: got %0d expected %0d", i, gport[i], exp_port);
            end
            if (i > 0) begin
                total++;
                if (gcyc[i] - gcyc[i-1] != 2) begin
                    bad++; $display("FAIL b2b_spacing%0d: got %0d expected 2", i, gcyc[i] - gcyc[i-1]);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_branch_hold;
        set_req(0, ALU_BEQ, 1'b0, 32'h108, 32'd3, 32'd3, 32'd4);
        bus.req_valid = 2'b01;
        #1;
        total++;
        if (bus.req_ready !== 2'b01) begin
            bad++; $display("FAIL beq_ready: got %b expected 01", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        tick();
        for (int k = 0; k < 5; k++) begin
            set_req(1, ALU_OR, 1'b0, 32'h0, 32'd1, 32'd2, 32'd0);
            bus.req_valid  = 2'b10;
            bus.resp_ready = 2'b10;
            #1;
            total++;
            if ({bus.resp_valid, bus.req_ready, bus.resp_br_enable, bus.resp_br_target, busy}
                !== {2'b01, 2'b00, 1'b1, 32'h114, 1'b1}) begin
                bad++; $display("FAIL beq_hold%0d: got rv=%b rdy=%b en=%b tgt=%h busy=%b expected 01/00/1/114/1",
                                k, bus.resp_valid, bus.req_ready, bus.resp_br_enable,
                                bus.resp_br_target, busy);
            end
            tick();
        end
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = 2'b00;
        total++;
        if ({bus.resp_valid, busy} !== {2'b00, 1'b0}) begin
            bad++; $display("FAIL beq_release: got rv=%b busy=%b expected 00/0", bus.resp_valid, busy);
        end
    endtask

    task automatic test_reset_mid;
        set_req(1, ALU_ADD, 1'b0, 32'h40, 32'd1, 32'd2, 32'd3);
        bus.req_valid = 2'b10;
        #1;
        tick();
        bus.req_valid = 2'b00;
        rst = 1'b1;
        tick();
        total++;
        if ({busy, bus.resp_valid} !== {1'b0, 2'b00}) begin
            bad++; $display("FAIL midrst_state: got busy=%b rv=%b expected 0/00", busy, bus.resp_valid);
        end
        total++;
        if ({alu_op, alu_check_overflow, alu_next_pc, alu_rs_val, alu_rt_val, alu_const_val} !== 135'h0) begin
            bad++; $display("FAIL midrst_alu: got op=%h rs=%h rt=%h expected 0", alu_op, alu_rs_val, alu_rt_val);
        end
        rst = 1'b0;
        tick();
        tick();
        total++;
        if ({busy, bus.resp_valid} !== {1'b0, 2'b00}) begin
            bad++; $display("FAIL midrst_no_resp: got busy=%b rv=%b expected 0/00", busy, bus.resp_valid);
        end
        run_single("after_reset", 0, ALU_SUB, 1'b0, 32'h0, 32'd50, 32'd8, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_add();
        test_overflow();
        test_back_to_back();
        test_branch_hold();
        test_unknown_op();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
